bram_writer: RTL and testbench

//  Key-driven writer for the board's 16x4 block RAM: the write side of the ROM/RAM reader.

---
 rtl/bram_pkg.sv | 24 ++
 rtl/key_debounce.sv | 55 +++++
 rtl/bram_writer.sv | 137 +++++++++++++
 tb/tb_bram_writer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared definitions for the 16x4 block-RAM writer and its reader:
// default geometry, FSM state encoding and the bulk-fill data pattern.
package bram_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_FILL    = 3'd4
  } state_e;

  // Fill word = latched switches XOR address. Callers pass zero-extended
  // operands and truncate the result to the data width, which selects the
  // low address bits or zero-extends the address as the widths demand.
  function automatic logic [31:0] fill_pattern(input logic [31:0] data,
                                               input logic [31:0] addr);
    return data ^ addr;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debouncer for one active-low push-button: 2-FF synchronizer, stability
// counter, and a one-cycle press pulse on the debounced 1->0 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_50,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, press_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronize the raw key into the clock domain; released (1) after reset.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
          press_q <= ~sync2_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/bram_writer.sv
// Key-driven writer for the board block RAM. KEY0 writes the switch value to
// an auto-incrementing address and reads it back; KEY1 fills the whole array
// with switches^address. A read-back mismatch sets a sticky error flag.
module bram_writer
  import bram_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic [1:0]        key,
  input  logic [DATA_W-1:0] sw,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] led,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [1:0] press;
  logic [1:0] level_unused;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
    .clk_50 (clk_50),
    .rst    (rst),
    .key_n  (key[0]),
    .level  (level_unused[0]),
    .press  (press[0])
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .clk_50 (clk_50),
    .rst    (rst),
    .key_n  (key[1]),
    .level  (level_unused[1]),
    .press  (press[1])
  );

  state_e            state_q;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [DATA_W-1:0] data_q;
  logic              ram_we_q, busy_q, err_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q, led_q;

  // Address increments; natural ADDR_W-bit overflow gives the wrap to 0.
  always_comb begin
    next_addr_d = next_addr_q + 1'b1;
    fill_addr_d = fill_addr_q + 1'b1;
  end

  // Writer FSM with registered RAM-port and status outputs. A press is only
  // acted on in IDLE, so presses while busy are dropped; KEY1 beats KEY0.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      next_addr_q <= '0;
      fill_addr_q <= '0;
      data_q      <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      led_q       <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press[1]) begin
            state_q     <= ST_FILL;
            fill_addr_q <= '0;
            data_q      <= sw;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= '0;
            ram_wdata_q <= DATA_W'(fill_pattern(32'(sw), 32'd0));
            busy_q      <= 1'b1;
          end else if (press[0]) begin
            state_q     <= ST_WRITE;
            data_q      <= sw;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= next_addr_q;
            ram_wdata_q <= sw;
            busy_q      <= 1'b1;
          end
        end
        ST_WRITE: begin
          ram_we_q <= 1'b0;
          led_q    <= data_q;
          state_q  <= ST_WAIT_RD;
        end
        // Address held with write enable low: a clean read of the new word.
        ST_WAIT_RD: begin
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (ram_rdata != data_q) err_q <= 1'b1;
          next_addr_q <= next_addr_d;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        ST_FILL: begin
          if (fill_addr_q == LAST_ADDR) begin
            ram_we_q    <= 1'b0;
            next_addr_q <= '0;
            led_q       <= data_q;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            fill_addr_q <= fill_addr_d;
            ram_addr_q  <= fill_addr_d;
            ram_wdata_q <= DATA_W'(fill_pattern(32'(data_q), 32'(fill_addr_d)));
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          ram_we_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign led       = led_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bram_writer.sv
// Bench for bram_writer: behavioural 16x4 RAM with 1-cycle read latency,
// directed key sequences, and a write scoreboard fed by the stimulus.
module tb_bram_writer;

  logic       clk_50 = 1'b0;
  logic       rst;
  logic [1:0] key;
  logic [3:0] sw;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata;
  logic [3:0] led;
  logic       busy;
  logic       err;

  int checks   = 0;
  int failures = 0;
  int we_count = 0;
  logic corrupt = 1'b0;

  logic [7:0] exp_q[$];
  logic [3:0] mem[16];
  logic [3:0] rdata_q;

  // clock / reset
  always #10 clk_50 = ~clk_50;

  bram_writer #(.ADDR_W(4), .DATA_W(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk_50    (clk_50),
    .rst       (rst),
    .key       (key),
    .sw        (sw),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .led       (led),
    .busy      (busy),
    .err       (err)
  );

  // RAM model; corrupt flips the returned word
  initial for (int i = 0; i < 16; i++) mem[i] = 4'h0;
  always @(posedge clk_50) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rdata_q <= mem[ram_addr];
  end
  assign ram_rdata = rdata_q ^ (corrupt ? 4'hF : 4'h0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every RAM write must match the head of exp_q
  always @(negedge clk_50) begin
    if (!rst && ram_we) begin
      we_count++;
      check("busy_during_write", {31'd0, busy}, 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {24'd0, ram_addr, ram_wdata}, 32'hFFFF);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("write_addr_data", {24'd0, ram_addr, ram_wdata}, {24'd0, e});
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk_50);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key = 2'b11;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_press(input logic [1:0] mask, input int hold);
    key = ~mask;
    repeat (hold) step();
    key = 2'b11;
    repeat (12) step();
    wait_idle("press_idle_timeout");
  endtask

  task automatic push_write(input logic [3:0] a, input logic [3:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic push_fill(input logic [3:0] s);
    for (int i = 0; i < 16; i++) push_write(4'(i), s ^ 4'(i));
  endtask

  initial begin
    int n;
    int base;
    rst = 1'b1;
    key = 2'b11;
    sw  = 4'h0;
    repeat (5) step();
    rst = 1'b0;

    // 1: idle after reset, keys released
    repeat (50) step();
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_addr", {28'd0, ram_addr}, 32'd0);
    check("rst_ram_wdata", {28'd0, ram_wdata}, 32'd0);
    check("rst_led", {28'd0, led}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_no_writes", we_count, 32'd0);

    // 2: single write of A to addr 0, with latency of busy
    sw = 4'hA;
    push_write(4'h0, 4'hA);
    key[0] = 1'b0;
    n = 0;
    while (!ram_we && n < 40) begin
      step();
      n++;
    end
    check("t2_we_seen", {31'd0, ram_we}, 32'd1);
    step();
    step();
    check("t2_busy_at_compare", {31'd0, busy}, 32'd1);
    step();
    check("t2_busy_low_after", {31'd0, busy}, 32'd0);
    repeat (4) step();
    key[0] = 1'b1;
    repeat (15) step();
    check("t2_led", {28'd0, led}, 32'hA);
    check("t2_err", {31'd0, err}, 32'd0);
    check("t2_one_write", we_count, 32'd1);

    // 3: bouncing key, never stable long enough
    base = we_count;
    for (int i = 0; i < 6; i++) begin
      key[0] = ~key[0];
      repeat (2) step();
    end
    key = 2'b11;
    repeat (20) step();
    check("t3_no_writes", we_count - base, 32'd0);

    // next write lands on addr 1; a long hold gives one pulse only
    sw = 4'h5;
    push_write(4'h1, 4'h5);
    base = we_count;
    do_press(2'b01, 30);
    check("hold_one_write", we_count - base, 32'd1);
    check("hold_led", {28'd0, led}, 32'h5);

    // 4: 16 writes of sw=addr, then wrap to addr 0
    do_reset();
    for (int i = 0; i < 16; i++) begin
      sw = 4'(i);
      push_write(4'(i), 4'(i));
      do_press(2'b01, 10);
    end
    for (int i = 0; i < 16; i++) check("t4_mem", {28'd0, mem[i]}, i);
    sw = 4'h5;
    push_write(4'h0, 4'h5);
    do_press(2'b01, 10);
    check("t4_err", {31'd0, err}, 32'd0);

    // 5: fill with 3, key0 pressed during the fill is dropped
    sw = 4'h3;
    push_fill(4'h3);
    base = we_count;
    key[1] = 1'b0;
    n = 0;
    while (!busy && n < 40) begin
      step();
      n++;
    end
    check("t5_busy_seen", {31'd0, busy}, 32'd1);
    key[0] = 1'b0;
    repeat (10) step();
    key = 2'b11;
    repeat (20) step();
    wait_idle("t5_fill_idle");
    check("t5_fill_writes", we_count - base, 32'd16);
    check("t5_led", {28'd0, led}, 32'h3);
    check("t5_queue_empty", exp_q.size(), 32'd0);
    sw = 4'h7;
    push_write(4'h0, 4'h7);
    do_press(2'b01, 10);
    check("t5_mem0", {28'd0, mem[0]}, 32'h7);

    // 6: corrupted read-back sets a sticky err; reset clears it
    do_reset();
    corrupt = 1'b1;
    sw = 4'h9;
    push_write(4'h0, 4'h9);
    do_press(2'b01, 10);
    corrupt = 1'b0;
    check("t6_err_set", {31'd0, err}, 32'd1);
    sw = 4'h2;
    push_write(4'h1, 4'h2);
    do_press(2'b01, 10);
    check("t6_err_sticky", {31'd0, err}, 32'd1);
    do_reset();
    check("t6_err_cleared", {31'd0, err}, 32'd0);

    // both keys in the same cycle: fill wins, no single write
    sw = 4'hC;
    push_fill(4'hC);
    base = we_count;
    do_press(2'b11, 10);
    check("t6_both_fill_writes", we_count - base, 32'd16);
    check("t6_both_led", {28'd0, led}, 32'hC);
    sw = 4'h1;
    push_write(4'h0, 4'h1);
    do_press(2'b01, 10);

    repeat (5) step();
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
